// File: rtl/sseg_frame_capture.sv
// Snoops a multiplexed seven-segment bus, debounces each digit slot and
// decodes complete frames of hex nibbles onto a valid/ready output.
module sseg_frame_capture #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [7:0]            sseg_p,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   err_out,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [N_DIGITS-1:0]   samp_an;
  logic [7:0]            samp_seg;
  logic [7:0]            cnt;
  logic [7:0]            cnt_nx;
  logic [4*N_DIGITS-1:0] sh_hex;
  logic [4*N_DIGITS-1:0] sh_hex_nx;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_dp_nx;
  logic [N_DIGITS-1:0]   sh_err;
  logic [N_DIGITS-1:0]   sh_err_nx;
  logic [N_DIGITS-1:0]   mask;
  logic [N_DIGITS-1:0]   mask_or;
  logic                  same;
  logic                  oh;
  logic                  capture;
  logic                  complete;
  logic [4:0]            dec;

  // {err, nibble}; unknown glyphs decode to 0 with err set
  function automatic logic [4:0] glyph(input logic [6:0] s);
    case (s)
      7'h3F:   glyph = 5'h00;
      7'h06:   glyph = 5'h01;
      7'h5B:   glyph = 5'h02;
      7'h4F:   glyph = 5'h03;
      7'h66:   glyph = 5'h04;
      7'h6D:   glyph = 5'h05;
      7'h7D:   glyph = 5'h06;
      7'h07:   glyph = 5'h07;
      7'h7F:   glyph = 5'h08;
      7'h6F:   glyph = 5'h09;
      7'h77:   glyph = 5'h0A;
      7'h7C:   glyph = 5'h0B;
      7'h39:   glyph = 5'h0C;
      7'h5E:   glyph = 5'h0D;
      7'h79:   glyph = 5'h0E;
      7'h71:   glyph = 5'h0F;
      default: glyph = 5'h10;
    endcase
  endfunction

  always_comb begin
    same = (an == samp_an) && (sseg_p == samp_seg);
    oh   = (an != '0) && ((an & (an - 1'b1)) == '0);
    if (!same || !oh)
      cnt_nx = 8'd0;
    else if (cnt == 8'hFF)
      cnt_nx = cnt;
    else
      cnt_nx = cnt + 8'd1;
    // count reaches LAST exactly once per window
    capture  = oh && (cnt_nx == LAST);
    mask_or  = mask | an;
    complete = capture && (&mask_or);
    dec      = glyph(sseg_p[6:0]);
  end

  always_comb begin
    sh_hex_nx = sh_hex;
    sh_dp_nx  = sh_dp;
    sh_err_nx = sh_err;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (an[i]) begin
        sh_hex_nx[4*i +: 4] = dec[3:0];
        sh_dp_nx[i]         = sseg_p[7];
        sh_err_nx[i]        = dec[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_an     <= '0;
      samp_seg    <= '0;
      cnt         <= '0;
      sh_hex      <= '0;
      sh_dp       <= '0;
      sh_err      <= '0;
      mask        <= '0;
      hex_out     <= '0;
      dp_out      <= '0;
      err_out     <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      samp_an  <= an;
      samp_seg <= sseg_p;
      cnt      <= cnt_nx;
      if (capture) begin
        sh_hex <= sh_hex_nx;
        sh_dp  <= sh_dp_nx;
        sh_err <= sh_err_nx;
        mask   <= complete ? '0 : mask_or;
      end
      if (complete) begin
        if (!frame_valid || frame_ready) begin
          hex_out     <= sh_hex_nx;
          dp_out      <= sh_dp_nx;
          err_out     <= sh_err_nx;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_frame_capture.sv
// Scoreboard bench for sseg_frame_capture: directed digit sequences push
// expected frames; a negedge monitor pops them on each accepted frame.
module tb_sseg_frame_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an = '0;
  logic [7:0]  sseg_p = '0;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        overrun;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  sseg_frame_capture #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .an(an), .sseg_p(sseg_p),
    .hex_out(hex_out), .dp_out(dp_out), .err_out(err_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      frame_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected got hex=%h dp=%b err=%b",
                 hex_out, dp_out, err_out);
      end else begin
        e = exp_q.pop_front();
        if ({hex_out, dp_out, err_out} !== e) begin
          errors++;
          $display("FAIL frame got hex=%h dp=%b err=%b exp hex=%h dp=%b err=%b",
                   hex_out, dp_out, err_out, e.hex, e.dp, e.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s,
                      input int n);
    an = a;
    sseg_p = s;
    tick(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    an = '0;
    sseg_p = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] h, input logic [3:0] d,
                      input logic [3:0] e);
    frame_t f;
    f.hex = h;
    f.dp = d;
    f.err = e;
    exp_q.push_back(f);
  endtask

  initial begin
    do_reset();
    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_dp", 32'(dp_out), 32'h0);
    chk("rst_err", 32'(err_out), 32'h0);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    // basic frame plus capture latency on the final digit
    frame_ready = 1'b1;
    push(16'h3210, 4'b1000, 4'b0000);
    hold(4'b0001, 8'h3F, 4);
    hold(4'b0010, 8'h06, 4);
    hold(4'b0100, 8'h5B, 4);
    an = 4'b1000;
    sseg_p = 8'hCF;
    for (int j = 0; j < 4; j++) begin
      tick(1);
      chk($sformatf("lat_edge%0d", j), 32'(frame_valid), 32'(j == 3));
    end
    tick(1);
    chk("one_cycle_valid", 32'(frame_valid), 32'h0);
    tick(4);
    chk("no_recapture", 32'(frame_valid), 32'h0);

    // glitches: short hold and mid-window toggle
    do_reset();
    frame_ready = 1'b1;
    hold(4'b0001, 8'h3F, 3);
    hold(4'b0010, 8'h06, 4);
    hold(4'b0100, 8'h5B, 4);
    hold(4'b1000, 8'h4F, 4);
    hold(4'b0000, 8'h00, 2);
    chk("glitch_no_frame", 32'(frame_valid), 32'h0);
    push(16'h3211, 4'b0000, 4'b0000);
    hold(4'b0001, 8'h3F, 2);
    chk("toggle_no_frame", 32'(frame_valid), 32'h0);
    hold(4'b0001, 8'h06, 3);
    chk("toggle_pending", 32'(frame_valid), 32'h0);
    hold(4'b0001, 8'h06, 1);
    chk("toggle_frame", 32'(frame_valid), 32'h1);
    hold(4'b0000, 8'h00, 2);

    // illegal glyphs and non-one-hot enables
    do_reset();
    frame_ready = 1'b1;
    push(16'h3010, 4'b0000, 4'b0100);
    hold(4'b0001, 8'h3F, 4);
    hold(4'b0010, 8'h06, 4);
    hold(4'b0100, 8'h00, 4);
    hold(4'b0100, 8'h49, 4);
    hold(4'b0011, 8'h7F, 10);
    chk("multi_an_no_frame", 32'(frame_valid), 32'h0);
    hold(4'b1000, 8'h4F, 4);
    hold(4'b0000, 8'h00, 2);

    // backpressure: second frame dropped
    do_reset();
    frame_ready = 1'b0;
    push(16'h1234, 4'b0000, 4'b0000);
    hold(4'b0001, 8'h66, 4);
    hold(4'b0010, 8'h4F, 4);
    hold(4'b0100, 8'h5B, 4);
    hold(4'b1000, 8'h06, 4);
    hold(4'b0001, 8'h7F, 4);
    hold(4'b0010, 8'h07, 4);
    hold(4'b0100, 8'h7D, 4);
    hold(4'b1000, 8'h6D, 4);
    chk("bp_hex", 32'(hex_out), 32'h1234);
    chk("bp_ovr", 32'(overrun), 32'h1);
    chk("bp_valid", 32'(frame_valid), 32'h1);
    frame_ready = 1'b1;
    tick(1);
    chk("bp_drop_valid", 32'(frame_valid), 32'h0);
    chk("bp_hex_kept", 32'(hex_out), 32'h1234);

    // acceptance coincides with completion
    do_reset();
    frame_ready = 1'b0;
    push(16'h1234, 4'b0000, 4'b0000);
    push(16'hABCD, 4'b0000, 4'b0000);
    hold(4'b0001, 8'h66, 4);
    hold(4'b0010, 8'h4F, 4);
    hold(4'b0100, 8'h5B, 4);
    hold(4'b1000, 8'h06, 4);
    hold(4'b0001, 8'h5E, 4);
    hold(4'b0010, 8'h39, 4);
    hold(4'b0100, 8'h7C, 4);
    hold(4'b1000, 8'h77, 3);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk("sim_valid", 32'(frame_valid), 32'h1);
    chk("sim_hex", 32'(hex_out), 32'hABCD);
    chk("sim_ovr", 32'(overrun), 32'h0);
    frame_ready = 1'b1;
    hold(4'b0000, 8'h00, 2);
    chk("sim_drained", 32'(frame_valid), 32'h0);

    // reset mid-frame discards partial capture
    do_reset();
    frame_ready = 1'b1;
    hold(4'b0001, 8'h3F, 4);
    hold(4'b0010, 8'h06, 4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    hold(4'b0100, 8'h5B, 4);
    hold(4'b1000, 8'h4F, 4);
    hold(4'b0000, 8'h00, 2);
    chk("mr_valid", 32'(frame_valid), 32'h0);
    chk("mr_hex", 32'(hex_out), 32'h0);
    chk("mr_dp", 32'(dp_out), 32'h0);
    chk("mr_err", 32'(err_out), 32'h0);

    chk("frames_outstanding", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
